// File: rtl/proc_trace_checker_if.sv
// Commit-trace bundle between a TinyRV1 core (master) and the trace checker (slave).
interface proc_trace_checker_if;
    logic        trace_val;
    logic [31:0] trace_addr;
    logic [31:0] trace_inst;
    logic [31:0] trace_data;

    modport master (output trace_val, trace_addr, trace_inst, trace_data);
    modport slave  (input  trace_val, trace_addr, trace_inst, trace_data);
endinterface

// File: rtl/proc_trace_checker.sv
// Checks a processor commit trace against a preloaded table of expected (addr, data)
// pairs and reports pass, address/data mismatch or timeout.
module proc_trace_checker #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_en,
    input  logic [$clog2(DEPTH)-1:0]   load_idx,
    input  logic [31:0]                load_addr,
    input  logic [31:0]                load_data,
    input  logic                       load_dc,
    input  logic [$clog2(DEPTH):0]     num_expected,
    input  logic                       start,
    proc_trace_checker_if.slave        trace,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [1:0]                 fail_code,
    output logic [$clog2(DEPTH)-1:0]   fail_idx,
    output logic [31:0]                fail_inst,
    output logic [31:0]                fail_data,
    output logic [$clog2(DEPTH):0]     match_count
);
    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned CW = IW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PASS,
        S_FAIL
    } state_t;

    state_t          state;
    logic [IW-1:0]   idx;
    logic [CW-1:0]   n;
    logic [TW-1:0]   idle_cnt;

    logic [31:0]     tab_addr [DEPTH];
    logic [31:0]     tab_data [DEPTH];
    logic            tab_dc   [DEPTH];

    logic [CW-1:0]   n_next;
    logic            addr_ok;
    logic            data_ok;
    logic            last;

    // Table is storage only: not reset, writable only while idle.
    always_ff @(posedge clk) begin
        if (!rst && load_en && state == S_IDLE) begin
            tab_addr[load_idx] <= load_addr;
            tab_data[load_idx] <= load_data;
            tab_dc[load_idx]   <= load_dc;
        end
    end

    always_comb begin
        n_next  = (num_expected > CW'(DEPTH)) ? CW'(DEPTH) : num_expected;
        addr_ok = (trace.trace_addr == tab_addr[idx]);
        data_ok = tab_dc[idx] || (trace.trace_data == tab_data[idx]);
        last    = ({1'b0, idx} == n - CW'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail_code   <= '0;
            fail_idx    <= '0;
            fail_inst   <= '0;
            fail_data   <= '0;
            match_count <= '0;
            idx         <= '0;
            idle_cnt    <= '0;
            n           <= '0;
        end else begin
            case (state)
                S_IDLE, S_PASS, S_FAIL: begin
                    if (start) begin
                        n           <= n_next;
                        idx         <= '0;
                        match_count <= '0;
                        idle_cnt    <= '0;
                        fail_code   <= '0;
                        fail_idx    <= '0;
                        fail_inst   <= '0;
                        fail_data   <= '0;
                        if (n_next == '0) begin
                            state <= S_PASS;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= 1'b1;
                        end else begin
                            state <= S_RUN;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                            pass  <= 1'b0;
                        end
                    end
                end

                S_RUN: begin
                    if (trace.trace_val) begin
                        idle_cnt <= '0;
                        if (!addr_ok || !data_ok) begin
                            state     <= S_FAIL;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            fail_code <= addr_ok ? 2'd2 : 2'd1;
                            fail_idx  <= idx;
                            fail_inst <= trace.trace_inst;
                            fail_data <= trace.trace_data;
                        end else begin
                            match_count <= match_count + CW'(1);
                            idx         <= idx + IW'(1);
                            if (last) begin
                                state <= S_PASS;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                pass  <= 1'b1;
                            end
                        end
                    end else if (idle_cnt == TW'(TIMEOUT - 1)) begin
                        // This idle cycle is the TIMEOUT-th in a row.
                        idle_cnt  <= idle_cnt + TW'(1);
                        state     <= S_FAIL;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        fail_code <= 2'd3;
                        fail_idx  <= idx;
                        fail_inst <= '0;
                        fail_data <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + TW'(1);
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_proc_trace_checker.sv
// Randomized scoreboard bench for proc_trace_checker: a run-level reference model
// predicts each run's verdict and completion cycle; a monitor checks on done rising.
module tb_proc_trace_checker;
    localparam int unsigned DEPTH   = 16;
    localparam int unsigned TIMEOUT = 4;
    localparam int unsigned IW      = 4;
    localparam int unsigned CW      = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_en;
    logic [IW-1:0] load_idx;
    logic [31:0]   load_addr;
    logic [31:0]   load_data;
    logic          load_dc;
    logic [CW-1:0] num_expected;
    logic          start;
    logic          busy;
    logic          done;
    logic          pass;
    logic [1:0]    fail_code;
    logic [IW-1:0] fail_idx;
    logic [31:0]   fail_inst;
    logic [31:0]   fail_data;
    logic [CW-1:0] match_count;

    proc_trace_checker_if tr ();

    proc_trace_checker #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .load_en      (load_en),
        .load_idx     (load_idx),
        .load_addr    (load_addr),
        .load_data    (load_data),
        .load_dc      (load_dc),
        .num_expected (num_expected),
        .start        (start),
        .trace        (tr),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .fail_code    (fail_code),
        .fail_idx     (fail_idx),
        .fail_inst    (fail_inst),
        .fail_data    (fail_data),
        .match_count  (match_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit          pass;
        int          code;
        int          fidx;
        logic [31:0] finst;
        logic [31:0] fdata;
        int          mcount;
        int          at;
    } exp_t;

    exp_t sbq[$];

    logic [31:0] m_addr [DEPTH];
    logic [31:0] m_data [DEPTH];
    bit          m_dc   [DEPTH];

    int          c_gap  [$];
    logic [31:0] c_addr [$];
    logic [31:0] c_inst [$];
    logic [31:0] c_data [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: one scoreboard entry is consumed per completed run.
    initial begin
        bit   prev_done;
        exp_t e;
        prev_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (done && !prev_done) begin
                if (sbq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1 expected no pending run (cycle %0d)", cyc);
                end else begin
                    e = sbq.pop_front();
                    chk("done_cycle",  cyc,         e.at);
                    chk("pass",        pass,        e.pass);
                    chk("busy",        busy,        0);
                    chk("fail_code",   fail_code,   e.code);
                    chk("fail_idx",    fail_idx,    e.fidx);
                    chk("fail_inst",   fail_inst,   e.finst);
                    chk("fail_data",   fail_data,   e.fdata);
                    chk("match_count", match_count, e.mcount);
                end
            end
            prev_done = done;
        end
    end

    task automatic clear_plan();
        c_gap.delete(); c_addr.delete(); c_inst.delete(); c_data.delete();
    endtask

    task automatic add_commit(input int gap, input logic [31:0] a, input logic [31:0] i,
                              input logic [31:0] d);
        c_gap.push_back(gap); c_addr.push_back(a); c_inst.push_back(i); c_data.push_back(d);
    endtask

    task automatic load(input int i, input logic [31:0] a, input logic [31:0] d, input bit dc);
        @(negedge clk);
        load_en = 1'b1; load_idx = IW'(i); load_addr = a; load_data = d; load_dc = dc;
        m_addr[i] = a; m_data[i] = d; m_dc[i] = dc;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Predicts the run outcome from the plan, then drives start and the commits.
    task automatic run_plan(input int n_req, input bit noisy);
        exp_t e;
        int   n, prev, m, ec;
        bit   found;
        @(negedge clk);
        n = (n_req > int'(DEPTH)) ? int'(DEPTH) : n_req;
        prev = cyc + 1;
        m = 0; found = 0;
        e.pass = 0; e.code = 0; e.fidx = 0; e.finst = '0; e.fdata = '0; e.at = 0;
        if (n == 0) begin
            e.pass = 1; e.at = prev; found = 1;
        end
        for (int j = 0; j < c_addr.size() && !found; j++) begin
            if (c_gap[j] >= int'(TIMEOUT)) begin
                e.code = 3; e.fidx = m; e.at = prev + int'(TIMEOUT); found = 1;
            end else begin
                ec = prev + c_gap[j] + 1;
                if (c_addr[j] != m_addr[m] || (!m_dc[m] && c_data[j] != m_data[m])) begin
                    e.code  = (c_addr[j] != m_addr[m]) ? 1 : 2;
                    e.fidx  = m;
                    e.finst = c_inst[j];
                    e.fdata = c_data[j];
                    e.at    = ec;
                    found   = 1;
                end else begin
                    m++;
                    if (m == n) begin
                        e.pass = 1; e.at = ec; found = 1;
                    end
                end
                prev = ec;
            end
        end
        if (!found) begin
            e.code = 3; e.fidx = m; e.at = prev + int'(TIMEOUT);
        end
        e.mcount = m;
        sbq.push_back(e);

        start = 1'b1; num_expected = CW'(n_req);
        @(negedge clk);
        start = 1'b0;
        for (int j = 0; j < c_addr.size(); j++) begin
            repeat (c_gap[j]) @(negedge clk);
            tr.trace_val = 1'b1; tr.trace_addr = c_addr[j];
            tr.trace_inst = c_inst[j]; tr.trace_data = c_data[j];
            if (noisy && $urandom_range(1) == 1) begin
                load_en = 1'b1; load_idx = IW'($urandom_range(DEPTH - 1));
                load_addr = $urandom; load_data = $urandom; load_dc = 1'($urandom_range(1));
            end
            @(negedge clk);
            tr.trace_val = 1'b0; load_en = 1'b0;
        end
    endtask

    task automatic drain();
        int b;
        b = 0;
        while (sbq.size() > 0 && b < 200) begin
            @(negedge clk);
            b++;
        end
        if (sbq.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL run_completion: got %0d pending runs after %0d cycles expected 0", sbq.size(), b);
            sbq.delete();
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"},        busy,        0);
        chk({tag, "_done"},        done,        0);
        chk({tag, "_pass"},        pass,        0);
        chk({tag, "_fail_code"},   fail_code,   0);
        chk({tag, "_fail_idx"},    fail_idx,    0);
        chk({tag, "_fail_inst"},   fail_inst,   0);
        chk({tag, "_fail_data"},   fail_data,   0);
        chk({tag, "_match_count"}, match_count, 0);
    endtask

    task automatic make_random_plan(output int n_req);
        int n, len, r;
        logic [31:0] a, d;
        n_req = 1 + $urandom_range(DEPTH - 1);
        if ($urandom_range(9) == 0) n_req = int'(DEPTH) + $urandom_range(15);
        n = (n_req > int'(DEPTH)) ? int'(DEPTH) : n_req;
        len = n;
        if ($urandom_range(7) == 0) len = $urandom_range(n - 1);
        clear_plan();
        for (int j = 0; j < len; j++) begin
            r = $urandom_range(19);
            a = m_addr[j];
            d = m_dc[j] ? $urandom : m_data[j];
            if ($urandom_range(11) == 0) a = a ^ (32'h1 << $urandom_range(31));
            else if ($urandom_range(11) == 0) d = d ^ (32'h1 << $urandom_range(31));
            add_commit(r < 15 ? 0 : (r < 19 ? $urandom_range(3, 1) : $urandom_range(5, 4)),
                       a, $urandom, d);
        end
    endtask

    initial begin
        int nr;
        rst = 1'b1; load_en = 1'b0; load_idx = '0; load_addr = '0; load_data = '0;
        load_dc = 1'b0; num_expected = '0; start = 1'b0;
        tr.trace_val = 1'b0; tr.trace_addr = '0; tr.trace_inst = '0; tr.trace_data = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_zero("reset");

        load(0, 32'h00, 32'h10, 1'b0);
        load(1, 32'h04, 32'h00, 1'b1);
        load(2, 32'h10, 32'h05, 1'b0);

        clear_plan();
        run_plan(0, 0);
        drain();

        add_commit(0, 32'h00, 32'h00a00093, 32'h10);
        add_commit(0, 32'h04, 32'h0000006f, 32'hdeadbeef);
        add_commit(0, 32'h10, 32'h00500093, 32'h05);
        run_plan(3, 0);
        drain();

        clear_plan();
        add_commit(0, 32'h00, 32'h00a00093, 32'h10);
        add_commit(0, 32'h04, 32'h0000006f, 32'h0);
        add_commit(0, 32'h10, 32'h00008067, 32'h06);
        run_plan(3, 0);
        drain();

        clear_plan();
        add_commit(0, 32'h00, 32'h00a00093, 32'h10);
        add_commit(0, 32'h08, 32'h12345678, 32'hbad0bad0);
        run_plan(3, 0);
        drain();

        repeat (2) begin
            clear_plan();
            add_commit(0, 32'h00, $urandom, 32'h10);
            add_commit(1, 32'h04, $urandom, $urandom);
            add_commit(2, 32'h10, $urandom, 32'h05);
            run_plan(3, 1);
            drain();
        end

        clear_plan();
        add_commit(0, 32'h00, 32'h00a00093, 32'h10);
        run_plan(2, 0);
        drain();

        // Reset mid-run after one match, then a fresh run from idle.
        @(negedge clk);
        start = 1'b1; num_expected = CW'(3);
        @(negedge clk);
        start = 1'b0;
        tr.trace_val = 1'b1; tr.trace_addr = 32'h00; tr.trace_inst = 32'h1; tr.trace_data = 32'h10;
        @(negedge clk);
        tr.trace_val = 1'b0;
        chk("midrun_busy", busy, 1);
        chk("midrun_match_count", match_count, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_zero("midrun_reset");
        clear_plan();
        add_commit(0, 32'h00, 32'h1, 32'h10);
        add_commit(0, 32'h04, 32'h2, 32'h77);
        add_commit(0, 32'h10, 32'h3, 32'h05);
        run_plan(3, 0);
        drain();

        do_reset();
        for (int i = 0; i < int'(DEPTH); i++)
            load(i, $urandom & 32'hfffffffc, $urandom, ($urandom_range(3) == 0));
        clear_plan();
        for (int i = 0; i < int'(DEPTH); i++)
            add_commit(0, m_addr[i], $urandom, m_dc[i] ? $urandom : m_data[i]);
        run_plan(int'(DEPTH) + 5, 0);
        drain();

        for (int k = 0; k < 40; k++) begin
            make_random_plan(nr);
            run_plan(nr, 1);
            drain();
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: got no completion expected finish before 500000 time units");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/proc_trace_checker.md
# proc_trace_checker

Hardware trace checker that sits on the commit-trace port of a TinyRV1 processor (`trace_val`/`trace_addr`/`trace_inst`/`trace_data`). It consumes that stream and compares each committed instruction against a preloaded table of expected (address, data) pairs. It reports pass, fail or timeout, so processor programs (jr, jal, branch tests) can be self-checked on an FPGA without a simulator bench. It is the receiving end of the trace interface the processor drives.

## Interface
- `DEPTH`, 16: number of expected-trace entries; power of two, 2–256.
- `TIMEOUT`, 64: consecutive cycles without `trace_val` in RUN before declaring a timeout; ≥ 2.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `load_en` in 1: write one expected entry this cycle (honoured only in IDLE).
- `load_idx` in log2(DEPTH): entry index to write.
- `load_addr` in 32: expected `trace_addr`.
- `load_data` in 32: expected `trace_data`.
- `load_dc` in 1: 1 = data is don't-care for this entry (instructions with no writeback).
- `num_expected` in log2(DEPTH)+1: entries to check; sampled on `start`.
- `start` in 1: begin a check run.
- `trace_val` in 1: processor commit-valid.
- `trace_addr` in 32: committed PC.
- `trace_inst` in 32: committed instruction word.
- `trace_data` in 32: committed writeback data.
- `busy` out 1: state is RUN.
- `done` out 1: state is PASS or FAIL.
- `pass` out 1: state is PASS.
- `fail_code` out 2: 0 none, 1 address mismatch, 2 data mismatch, 3 timeout.
- `fail_idx` out log2(DEPTH): entry index at failure.
- `fail_inst` out 32: `trace_inst` of the failing commit (0 on timeout).
- `fail_data` out 32: `trace_data` of the failing commit (0 on timeout).
- `match_count` out log2(DEPTH)+1: entries matched in the current or last run.

## Operation
- States: IDLE, RUN, PASS, FAIL. Reset: IDLE. All outputs are 0, `idx` = 0, and the idle counter is 0. Table contents are not reset.
- IDLE:
  - `load_en` writes {addr, data, dc} at `load_idx`.
  - `start` latches `n = min(num_expected, DEPTH)` and clears `idx`, `match_count`, the idle counter and the fail fields.
  - With `n == 0`, the block goes to PASS. Otherwise it goes to RUN.
  - `load_en` and `start` asserted together: the write takes effect, then the run starts. The entry is usable in the run.
- RUN:
  - Each cycle with `trace_val` = 0 increments the idle counter. When it reaches `TIMEOUT`, the block goes to FAIL with code 3 and `fail_idx` = `idx`.
  - `trace_val` = 1 clears the idle counter and compares against entry `idx`.
  - Address mismatch: FAIL, code 1. This check has priority over the data check.
  - Otherwise, data mismatch with dc = 0: FAIL, code 2.
  - Otherwise: `match_count`++ and `idx`++. If `idx` was `n-1`, the block goes to PASS.
  - On failure, `fail_inst` and `fail_data` capture the failing commit's `trace_inst` and `trace_data`.
- PASS/FAIL:
  - Results hold and further trace activity is ignored.
  - `start` begins a new run exactly as from IDLE, using the current table.
  - `load_en` is ignored.
- Ignored cases:
  - `load_en` and `start` are ignored in RUN.
  - `trace_val` is ignored outside RUN.
- Comparisons use all 32 bits with exact equality.
- `match_count` never exceeds `n`.

## Timing
- All outputs are registered.
- A `start` sampled at edge k: `busy` is high after edge k. With n = 0, `pass` is high after edge k.
- A commit sampled at edge k is compared combinationally against the table. Its result (`match_count`, `pass`/`fail_*`) is visible after edge k, and `busy` drops at that same edge on the final or failing commit.
- Back-to-back `trace_val` on consecutive cycles is fully supported, one compare per cycle with no stall.
- Timeout: with the last commit (or `start`) at edge k and no further `trace_val`, `fail_code` = 3 is visible after edge k+`TIMEOUT`.
- `rst` at any edge, including mid-RUN, forces IDLE and zeroes outputs at that edge. `rst` has priority over `start` and `load_en`.

## Test plan
- Pass run: load {0x00,0x10}, {0x04,dc}, {0x10,0x05}. `start` with n = 3, then drive those three commits on consecutive cycles → `pass` = 1 the cycle after the third commit, `match_count` = 3, `fail_code` = 0.
- Data mismatch: same table, third commit carries data 0x06 with inst 0x00008067 → FAIL, `fail_code` = 2, `fail_idx` = 2, `fail_data` = 0x06, `fail_inst` = 0x00008067, `match_count` = 2.
- Address/priority: the second commit has addr 0x08 and wrong data → `fail_code` = 1, `fail_idx` = 1. A don't-care entry with any data passes.
- Timeout: `TIMEOUT` = 4, `start` with n = 2, one matching commit, then `trace_val` low → `fail_code` = 3 exactly 4 cycles after that commit; `fail_inst` = 0.
- Edge cases: `start` with n = 0 → `pass` next cycle. n = DEPTH+5 saturates to DEPTH. `load_en` during RUN does not alter the table. `start` from PASS reruns, clearing `match_count`.
- Reset mid-RUN after 1 match → all outputs 0 and state IDLE. A new `start` passes with a fresh trace.
